// File: rtl/xc_aessub_seq.sv
// AES SubBytes sequencer: walks the four state columns through one SubBytes unit
// over a valid/ready port, optionally fusing (Inv)ShiftRows into the final result.
module xc_aessub_seq #(
    parameter bit SHIFT_ROWS = 1'b1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic         start,
    input  logic         enc,
    input  logic [127:0] state_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] state_out,
    output logic         sub_valid,
    output logic [31:0]  sub_rs1,
    output logic [31:0]  sub_rs2,
    output logic         sub_enc,
    output logic         sub_rot,
    output logic         sub_flush,
    input  logic         sub_ready,
    input  logic [31:0]  sub_result
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_CLEAR = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic         enc_q, enc_d;
    logic [127:0] in_q, in_d;
    logic [127:0] work_q, work_d;
    logic [127:0] out_q, out_d;

    // Byte (r,c) sits at index 4c+r; forward rotates row r left by r, inverse right by r.
    function automatic logic [127:0] shift_rows(input logic [127:0] w, input logic fwd);
        logic [127:0] res;
        logic [1:0]   src;
        res = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                src = fwd ? 2'(c + r) : 2'(c + 4 - r);
                res[8*(4*c+r) +: 8] = w[8*(4*src+r) +: 8];
            end
        end
        return res;
    endfunction

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        enc_d     = enc_q;
        in_d      = in_q;
        work_d    = work_q;
        out_d     = out_q;
        done      = 1'b0;
        sub_valid = 1'b0;
        sub_flush = 1'b0;

        if (flush && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            sub_flush = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && !flush) begin
                        in_d    = state_in;
                        enc_d   = enc;
                        col_d   = '0;
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    sub_valid = 1'b1;
                    if (sub_ready) begin
                        work_d[{col_q, 5'd0} +: 32] = sub_result;
                        state_d = S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    sub_flush = 1'b1;
                    if (col_q == 2'd3) begin
                        state_d = S_DONE;
                    end else begin
                        col_d   = col_q + 2'd1;
                        state_d = S_ISSUE;
                    end
                end
                S_DONE: begin
                    done    = 1'b1;
                    out_d   = SHIFT_ROWS ? shift_rows(work_q, enc_q) : work_q;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            enc_q   <= 1'b0;
            in_q    <= '0;
            work_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            enc_q   <= enc_d;
            in_q    <= in_d;
            work_q  <= work_d;
            out_q   <= out_d;
        end
    end

    // Both operands carry the same column so the unit substitutes all four bytes.
    assign sub_rs1   = in_q[{col_q, 5'd0} +: 32];
    assign sub_rs2   = in_q[{col_q, 5'd0} +: 32];
    assign sub_enc   = enc_q;
    assign sub_rot   = 1'b0;
    assign busy      = (state_q != S_IDLE);
    assign state_out = out_q;

endmodule

// File: tb/tb_xc_aessub_seq.sv
// Directed/random bench for xc_aessub_seq with behavioural SubBytes unit models
// (configurable latency) and an S-box derived from GF(2^8) arithmetic.
module tb_xc_aessub_seq;

    logic         clock = 1'b0;
    logic         reset, flush, start, enc;
    logic [127:0] state_in, state_out;
    logic         busy, done, sub_valid, sub_enc, sub_rot, sub_flush, sub_ready;
    logic [31:0]  sub_rs1, sub_rs2, sub_result;

    logic         flush0, start0, enc0;
    logic [127:0] state_in0, state_out0;
    logic         busy0, done0, sub_valid0, sub_enc0, sub_rot0, sub_flush0, sub_ready0;
    logic [31:0]  sub_rs1_0, sub_rs2_0, sub_result0;

    int unsigned n_vec = 0, n_err = 0;
    int unsigned lat = 1, ucnt = 0;
    logic        force_ready = 1'b0;
    logic [7:0]  sbox  [256];
    logic [7:0]  isbox [256];

    always #5 clock = ~clock;

    xc_aessub_seq #(.SHIFT_ROWS(1'b1)) dut (
        .clock(clock), .reset(reset), .flush(flush), .start(start), .enc(enc),
        .state_in(state_in), .busy(busy), .done(done), .state_out(state_out),
        .sub_valid(sub_valid), .sub_rs1(sub_rs1), .sub_rs2(sub_rs2), .sub_enc(sub_enc),
        .sub_rot(sub_rot), .sub_flush(sub_flush), .sub_ready(sub_ready), .sub_result(sub_result)
    );

    xc_aessub_seq #(.SHIFT_ROWS(1'b0)) dut0 (
        .clock(clock), .reset(reset), .flush(flush0), .start(start0), .enc(enc0),
        .state_in(state_in0), .busy(busy0), .done(done0), .state_out(state_out0),
        .sub_valid(sub_valid0), .sub_rs1(sub_rs1_0), .sub_rs2(sub_rs2_0), .sub_enc(sub_enc0),
        .sub_rot(sub_rot0), .sub_flush(sub_flush0), .sub_ready(sub_ready0), .sub_result(sub_result0)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = '0; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] unit_fn(input logic [31:0] w, input logic e);
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[8*i +: 8] = e ? sbox[w[8*i +: 8]] : isbox[w[8*i +: 8]];
        return res;
    endfunction

    // Reference: out(r,c) = box(in(r, src)), src = c, (c+r)%4 or (c-r)%4.
    function automatic logic [127:0] ref_model(input logic [127:0] st, input logic e, input logic shift);
        logic [127:0] o;
        int src;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = !shift ? c : (e ? (c + r) % 4 : (c - r + 4) % 4);
                o[8*(4*c+r) +: 8] = e ? sbox[st[8*(4*src+r) +: 8]] : isbox[st[8*(4*src+r) +: 8]];
            end
        end
        return o;
    endfunction

    // Unit models: result of the byte mix {rs2,rs1,rs2,rs1}; main unit answers after lat cycles.
    assign sub_result  = unit_fn({sub_rs2[31:24], sub_rs1[23:16], sub_rs2[15:8], sub_rs1[7:0]}, sub_enc);
    assign sub_ready   = (sub_valid && ucnt == lat - 1) || force_ready;
    assign sub_result0 = unit_fn({sub_rs2_0[31:24], sub_rs1_0[23:16], sub_rs2_0[15:8], sub_rs1_0[7:0]}, sub_enc0);
    assign sub_ready0  = sub_valid0;

    always @(posedge clock) begin
        if (!sub_valid || sub_flush || sub_ready) ucnt <= 0;
        else ucnt <= ucnt + 1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // One full operation; a different operand is pulsed on start mid-flight and must be ignored.
    task automatic run_op(input logic [127:0] st, input logic e, input int unsigned exp_lat,
                          input logic [127:0] st_alt, output logic [127:0] res);
        int unsigned t, flushes;
        logic prev_f;
        state_in = st; enc = e; start = 1'b1;
        tick();
        start = 1'b0; state_in = st_alt; enc = ~e;
        t = 1; flushes = 0; prev_f = 1'b0;
        while (!done && t < 400) begin
            if (sub_valid) begin
                chk("rs1_word", {96'd0, sub_rs1}, {96'd0, st[32*flushes +: 32]});
                chk("rs2_word", {96'd0, sub_rs2}, {96'd0, st[32*flushes +: 32]});
                chk("sub_enc", {127'd0, sub_enc}, {127'd0, e});
            end
            if (sub_flush) begin
                chk("flush_width", {127'd0, prev_f}, 128'd0);
                flushes++;
            end
            prev_f = sub_flush;
            start = (t == 3);
            tick();
            t++;
        end
        start = 1'b0;
        chk("latency", 128'(t), 128'(exp_lat));
        chk("flush_count", 128'(flushes), 128'd4);
        chk("done_high", {127'd0, done}, 128'd1);
        tick();
        chk("done_pulse", {127'd0, done}, 128'd0);
        chk("state_out", state_out, ref_model(st, e, 1'b1));
        res = state_out;
    endtask

    initial begin
        logic [127:0] r, c, p, saved;
        int unsigned t, fl;
        logic bad;
        logic [7:0] b, inv;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);

        reset = 1'b1; flush = 1'b0; start = 1'b0; enc = 1'b0; state_in = '0;
        flush0 = 1'b0; start0 = 1'b0; enc0 = 1'b0; state_in0 = '0;
        repeat (2) tick();
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_done", {127'd0, done}, 128'd0);
        chk("rst_valid", {127'd0, sub_valid}, 128'd0);
        chk("rst_subflush", {127'd0, sub_flush}, 128'd0);
        chk("rst_out", state_out, 128'd0);
        chk("rst_enc", {127'd0, sub_enc}, 128'd0);
        chk("rst_rot", {127'd0, sub_rot}, 128'd0);
        chk("rst_busy0", {127'd0, busy0}, 128'd0);
        chk("rst_rot0", {127'd0, sub_rot0}, 128'd0);
        chk("rst_subflush0", {127'd0, sub_flush0}, 128'd0);
        reset = 1'b0;
        tick();

        // zero state, forward, 1-cycle unit
        run_op('0, 1'b1, 9, {$urandom, $urandom, $urandom, $urandom}, c);
        chk("all_63", c, {16{8'h63}});

        // SubBytes only, byte k = k
        for (int k = 0; k < 16; k++) state_in0[8*k +: 8] = 8'(k);
        enc0 = 1'b1; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("enc0_latched", {127'd0, sub_enc0}, 128'd1);
        t = 1;
        while (!done0 && t < 100) begin tick(); t++; end
        chk("latency0", 128'(t), 128'd9);
        tick();
        chk("noshift_const", state_out0, 128'h76abd7fe2b670130c56f6bf27b777c63);
        chk("noshift_model", state_out0, ref_model(state_in0, 1'b1, 1'b0));

        // round trips with random states
        for (int i = 0; i < 3; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            run_op(r, 1'b1, 9, {$urandom, $urandom, $urandom, $urandom}, c);
            run_op(c, 1'b0, 9, {$urandom, $urandom, $urandom, $urandom}, p);
            chk("roundtrip", p, r);
        end

        // 4-cycle unit
        lat = 4;
        r = {$urandom, $urandom, $urandom, $urandom};
        run_op(r, 1'b1, 21, {$urandom, $urandom, $urandom, $urandom}, c);
        run_op(c, 1'b0, 21, {$urandom, $urandom, $urandom, $urandom}, p);
        chk("roundtrip_lat4", p, r);
        lat = 1;

        // spurious ready while idle
        force_ready = 1'b1;
        repeat (3) tick();
        chk("spur_busy", {127'd0, busy}, 128'd0);
        chk("spur_done", {127'd0, done}, 128'd0);
        force_ready = 1'b0;

        // flush during column 2 issue
        saved = state_out;
        state_in = {$urandom, $urandom, $urandom, $urandom}; enc = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        t = 0; fl = 0;
        while (!(sub_valid && fl == 2) && t < 100) begin
            if (sub_flush) fl++;
            tick();
            t++;
        end
        chk("reach_col2", 128'(fl), 128'd2);
        flush = 1'b1;
        #1;
        chk("flush_valid", {127'd0, sub_valid}, 128'd0);
        chk("flush_subflush", {127'd0, sub_flush}, 128'd1);
        chk("flush_done", {127'd0, done}, 128'd0);
        tick();
        flush = 1'b0;
        chk("flush_idle", {127'd0, busy}, 128'd0);
        bad = 1'b0;
        repeat (12) begin
            if (done) bad = 1'b1;
            tick();
        end
        chk("flush_nodone", {127'd0, bad}, 128'd0);
        chk("flush_keep_out", state_out, saved);

        // flush beats start in idle
        start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("flush_over_start", {127'd0, busy}, 128'd0);

        r = {$urandom, $urandom, $urandom, $urandom};
        run_op(r, 1'b1, 9, {$urandom, $urandom, $urandom, $urandom}, c);

        // reset mid-operation
        state_in = {$urandom, $urandom, $urandom, $urandom}; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        chk("mid_rst_busy", {127'd0, busy}, 128'd0);
        chk("mid_rst_done", {127'd0, done}, 128'd0);
        chk("mid_rst_valid", {127'd0, sub_valid}, 128'd0);
        chk("mid_rst_out", state_out, 128'd0);
        reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
